// File: rtl/sys_mem_arb.sv
// sys_mem_arb - round-robin arbiter sharing one system memory port between
// NUM_AGENTS requesters (host access block, ADV7513 display controller, ...).
//
// The granted agent's request passes combinationally to the memory port.
// A grant that stalls is frozen in HOLD until the memory accepts it. Read
// data comes back in order. A tag FIFO records which agent issued each
// accepted read, so every returning beat is steered to that agent.
//
// Optional feature macro: SYS_MEM_ARB_PRIO_EN
//   defined   : PRIO_AGENT wins every IDLE arbitration it takes part in;
//               the others rotate round-robin. HOLD is never pre-empted.
//   undefined : pure round-robin; PRIO_AGENT only gets a range check.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   agt_wren/agt_rden   per-agent write/read request (wren wins if both set)
//   agt_addr/agt_wdata  per-agent address / write data (unpacked arrays)
//   agt_wait            per-agent stall
//   agt_rd_valid        per-agent read data strobe
//   agt_rdata           per-agent read data (every lane carries mem_rdata)
//   mem_*               single memory controller port
//   rd_orphan           sticky: read data arrived with no read outstanding
//
// RD_TAG_DEPTH must be a power of two and at least 2.
module sys_mem_arb #(
  parameter int NUM_AGENTS   = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 27,
  parameter int RD_TAG_DEPTH = 8,
  parameter int PRIO_AGENT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_AGENTS-1:0] agt_wren,
  input  logic [NUM_AGENTS-1:0] agt_rden,
  input  logic [ADDR_W-1:0]     agt_addr     [NUM_AGENTS],
  input  logic [DATA_W-1:0]     agt_wdata    [NUM_AGENTS],
  output logic [NUM_AGENTS-1:0] agt_wait,
  output logic [NUM_AGENTS-1:0] agt_rd_valid,
  output logic [DATA_W-1:0]     agt_rdata    [NUM_AGENTS],
  input  logic                  mem_wait,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rd_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rd_orphan
);

  localparam int ID_W  = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
  localparam int PTR_W = $clog2(RD_TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (PRIO_AGENT < 0 || PRIO_AGENT >= NUM_AGENTS) begin : g_bad_prio
    $error("sys_mem_arb: PRIO_AGENT out of range");
  end

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         hold_id_q, hold_id_d;
  logic [ID_W-1:0]         last_q;
  logic                    run_q;
  logic                    run;
  logic [NUM_AGENTS-1:0]   req;
  logic                    rr_vld;
  logic [ID_W-1:0]         rr_id;
  logic [ID_W-1:0]         cand;
  logic                    gnt_vld;
  logic [ID_W-1:0]         gnt_id;
  logic                    gnt_wr;
  logic                    gnt_rd;
  logic                    rd_blocked;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    tag_full;
  logic                    tag_empty;
  logic [ID_W-1:0]         tag_mem [RD_TAG_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    rd_orphan_q;

  // Outputs are live only when reset is released and has been seen released
  // at least once by the registered flag.
  assign run       = rst_n & run_q;
  assign req       = agt_wren | agt_rden;
  assign tag_full  = (cnt_q == CNT_W'(RD_TAG_DEPTH));
  assign tag_empty = (cnt_q == '0);

  // Round-robin search starting just after the last accepted agent.
  always_comb begin
    rr_vld = 1'b0;
    rr_id  = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_AGENTS; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_AGENTS);
      if (!rr_vld && req[cand]) begin
        rr_vld = 1'b1;
        rr_id  = cand;
      end
    end
  end

  // Grant selection, accept decision and next state.
  always_comb begin
    state_d   = state_q;
    hold_id_d = hold_id_q;
    gnt_vld   = rr_vld;
    gnt_id    = rr_id;
    case (state_q)
      ST_IDLE: begin
`ifdef SYS_MEM_ARB_PRIO_EN
        if (req[PRIO_AGENT]) begin
          gnt_vld = 1'b1;
          gnt_id  = ID_W'(PRIO_AGENT);
        end
`endif
      end
      ST_HOLD: begin
        gnt_vld = req[hold_id_q];
        gnt_id  = hold_id_q;
      end
      default: ;
    endcase
    gnt_wr     = gnt_vld & agt_wren[gnt_id];
    gnt_rd     = gnt_vld & agt_rden[gnt_id] & ~agt_wren[gnt_id];
    // Uses the registered count, so a pop in the same cycle does not unblock.
    rd_blocked = gnt_rd & tag_full;
    accept     = run & gnt_vld & ~mem_wait & ~rd_blocked;
    if (run && gnt_vld) begin
      if (accept) begin
        state_d = ST_IDLE;
      end else begin
        state_d   = ST_HOLD;
        hold_id_d = gnt_id;
      end
    end
  end

  assign push = accept & gnt_rd;
  assign pop  = run & mem_rd_valid & ~tag_empty;

  assign mem_wren  = run & gnt_wr;
  assign mem_rden  = run & gnt_rd & ~rd_blocked;
  assign mem_addr  = (run && gnt_vld) ? agt_addr[gnt_id]  : '0;
  assign mem_wdata = (run && gnt_vld) ? agt_wdata[gnt_id] : '0;
  assign rd_orphan = rd_orphan_q;

  always_comb begin
    agt_wait     = '1;
    agt_rd_valid = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      agt_rdata[i] = mem_rdata;
      if (run && gnt_vld && gnt_id == ID_W'(i)) begin
        agt_wait[i] = mem_wait | rd_blocked;
      end
    end
    if (pop) begin
      agt_rd_valid[tag_mem[rd_ptr_q]] = 1'b1;
    end
  end

  // Control state: arbiter, FIFO pointers, sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_id_q   <= '0;
      last_q      <= ID_W'(NUM_AGENTS - 1);
      run_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_orphan_q <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      state_q   <= state_d;
      hold_id_q <= hold_id_d;
      if (accept) last_q <= gnt_id;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (mem_rd_valid && tag_empty) rd_orphan_q <= 1'b1;
    end
  end

  // Tag storage carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= gnt_id;
  end

endmodule

// File: tb/tb_sys_mem_arb.sv
module tb_sys_mem_arb;
  localparam int N     = 2;
  localparam int DW    = 32;
  localparam int AW    = 27;
  localparam int DEPTH = 8;
  localparam int PRIO  = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  agt_wren, agt_rden, agt_wait, agt_rd_valid;
  logic [AW-1:0] agt_addr  [N];
  logic [DW-1:0] agt_wdata [N];
  logic [DW-1:0] agt_rdata [N];
  logic          mem_wait, mem_wren, mem_rden, mem_rd_valid, rd_orphan;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  sys_mem_arb #(.NUM_AGENTS(N), .DATA_W(DW), .ADDR_W(AW),
                .RD_TAG_DEPTH(DEPTH), .PRIO_AGENT(PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .agt_wren(agt_wren), .agt_rden(agt_rden),
    .agt_addr(agt_addr), .agt_wdata(agt_wdata),
    .agt_wait(agt_wait), .agt_rd_valid(agt_rd_valid), .agt_rdata(agt_rdata),
    .mem_wait(mem_wait), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata), .rd_orphan(rd_orphan)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending agent requests, rotation pointer, stalled
  // grant, queue of outstanding read owners, sticky orphan flag.
  bit            p_wr [N];
  bit            p_rd [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  int            m_last;
  bit            m_hold;
  int            m_hold_id;
  int            m_tags [$];
  bit            m_orphan;
  bit            refill;

  // Observed DUT behaviour for directed order checks.
  int            obs_acc [$];
  int            obs_rdv [$];
  logic [DW-1:0] obs_rdat [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int i, input int kind);
    p_wr[i]   = (kind != 1);
    p_rd[i]   = (kind != 0);
    p_addr[i] = AW'($urandom());
    p_data[i] = $urandom();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      agt_wren[i]  = p_wr[i];
      agt_rden[i]  = p_rd[i];
      agt_addr[i]  = p_addr[i];
      agt_wdata[i] = p_data[i];
    end
  endtask

  task automatic check_gated();
    check_val("rst_wait",  64'(agt_wait), 64'({N{1'b1}}));
    check_val("rst_wren",  64'(mem_wren), 64'(0));
    check_val("rst_rden",  64'(mem_rden), 64'(0));
    check_val("rst_addr",  64'(mem_addr), 64'(0));
    check_val("rst_wdata", 64'(mem_wdata), 64'(0));
    check_val("rst_rdv",   64'(agt_rd_valid), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) new_req(i, 2);
    drive();
    mem_wait = 1'b0; mem_rd_valid = 1'b1; mem_rdata = 32'hdead_beef;
    #1 check_gated();
    @(negedge clk);
    #1 check_gated();
    check_val("rst_orphan", 64'(rd_orphan), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin p_wr[i] = 0; p_rd[i] = 0; end
    drive();
    mem_rd_valid = 1'b0;
    m_last = N - 1; m_hold = 0; m_tags.delete(); m_orphan = 0; refill = 0;
    obs_acc.delete(); obs_rdv.delete(); obs_rdat.delete();
  endtask

  task automatic cycle(input bit mw, input bit rv, input logic [DW-1:0] rdat);
    int g; bit gv; bit rdk; bit blk; bit acc;
    logic [N-1:0] ew; logic [N-1:0] erv;
    @(negedge clk);
    drive();
    mem_wait = mw; mem_rd_valid = rv; mem_rdata = rdat;
    #1;
    gv = 0; g = 0;
    if (m_hold) begin
      gv = 1; g = m_hold_id;
    end else begin
`ifdef SYS_MEM_ARB_PRIO_EN
      if (p_wr[PRIO] || p_rd[PRIO]) begin gv = 1; g = PRIO; end
`endif
      for (int k = 1; k <= N && !gv; k++) begin
        int c;
        c = (m_last + k) % N;
        if (p_wr[c] || p_rd[c]) begin gv = 1; g = c; end
      end
    end
    rdk = gv && p_rd[g] && !p_wr[g];
    blk = rdk && (m_tags.size() == DEPTH);
    acc = gv && !mw && !blk;
    ew  = '1;
    if (gv) ew[g] = mw | blk;
    erv = '0;
    if (rv && m_tags.size() > 0) erv[m_tags[0]] = 1'b1;
    check_val("mem_wren",  64'(mem_wren), 64'(gv && p_wr[g]));
    check_val("mem_rden",  64'(mem_rden), 64'(rdk && !blk));
    check_val("mem_addr",  64'(mem_addr), gv ? 64'(p_addr[g]) : 64'(0));
    check_val("mem_wdata", 64'(mem_wdata), gv ? 64'(p_data[g]) : 64'(0));
    check_val("agt_wait",  64'(agt_wait), 64'(ew));
    check_val("agt_rd_valid", 64'(agt_rd_valid), 64'(erv));
    check_val("agt_rdata", 64'(agt_rdata[N-1]), 64'(rdat));
    check_val("rd_orphan", 64'(rd_orphan), 64'(m_orphan));
    if (!mw && (mem_wren || mem_rden))
      for (int i = 0; i < N; i++) if (!agt_wait[i]) obs_acc.push_back(i);
    for (int i = 0; i < N; i++)
      if (agt_rd_valid[i]) begin obs_rdv.push_back(i); obs_rdat.push_back(agt_rdata[i]); end
    if (rv) begin
      if (m_tags.size() == 0) m_orphan = 1;
      else void'(m_tags.pop_front());
    end
    if (acc) begin
      if (rdk) m_tags.push_back(g);
      m_last = g; m_hold = 0;
      p_wr[g] = 0; p_rd[g] = 0;
      if (refill) new_req(g, 0);
    end else if (gv) begin
      m_hold = 1; m_hold_id = g;
    end
  endtask

  function automatic logic [63:0] q_at(input int q[$], input int k);
    return (q.size() > k) ? 64'(q[k]) : 64'hffff_ffff_ffff_ffff;
  endfunction

  initial begin
    mem_wait = 1'b0; mem_rd_valid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < N; i++) begin p_wr[i] = 0; p_rd[i] = 0; p_addr[i] = '0; p_data[i] = '0; end
    drive();

    // Continuous writes from both agents alternate, agent 0 first.
    do_reset();
    refill = 1; new_req(0, 0); new_req(1, 0);
    for (int c = 0; c < 6; c++) cycle(0, 0, '0);
    for (int k = 0; k < 6; k++) check_val("rr_order", q_at(obs_acc, k), 64'(k % 2));

    // Stall: agent 1 granted, memory waits 3 cycles, agent 0 must wait.
    do_reset();
    new_req(0, 0); cycle(0, 0, '0);
    new_req(0, 0); new_req(1, 0); obs_acc.delete();
    for (int c = 0; c < 3; c++) begin
      cycle(1, 0, '0);
      check_val("hold_wait", 64'(agt_wait), 64'(2'b11));
      check_val("hold_addr", 64'(mem_addr), 64'(p_addr[1]));
    end
    cycle(0, 0, '0); cycle(0, 0, '0);
    check_val("hold_acc0", q_at(obs_acc, 0), 64'(1));
    check_val("hold_acc1", q_at(obs_acc, 1), 64'(0));

    // In-order read routing A0, A1, A1, A0.
    do_reset();
    new_req(0, 1); cycle(0, 0, '0);
    new_req(1, 1); cycle(0, 0, '0);
    new_req(1, 1); cycle(0, 0, '0);
    new_req(0, 1); cycle(0, 0, '0);
    for (int k = 1; k <= 4; k++) cycle(0, 1, DW'(k * 32'h11));
    check_val("rd_lane0", q_at(obs_rdv, 0), 64'(0));
    check_val("rd_lane1", q_at(obs_rdv, 1), 64'(1));
    check_val("rd_lane2", q_at(obs_rdv, 2), 64'(1));
    check_val("rd_lane3", q_at(obs_rdv, 3), 64'(0));
    for (int k = 0; k < 4; k++)
      check_val("rd_data", (obs_rdat.size() > k) ? 64'(obs_rdat[k]) : 64'hffff_ffff_ffff_ffff,
                64'((k + 1) * 32'h11));

    // Full tag FIFO blocks the 9th read until the cycle after a return.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin new_req(k % N, 1); cycle(0, 0, '0); end
    new_req(0, 1);
    cycle(0, 0, '0);
    check_val("full_wait", 64'(agt_wait[0]), 64'(1));
    check_val("full_rden", 64'(mem_rden), 64'(0));
    cycle(0, 1, 32'h55);
    check_val("full_pop_rden", 64'(mem_rden), 64'(0));
    cycle(0, 0, '0);
    check_val("unblk_rden", 64'(mem_rden), 64'(1));
    check_val("unblk_wait", 64'(agt_wait[0]), 64'(0));

    // Reset with reads outstanding, then stray data is orphaned.
    do_reset();
    cycle(0, 1, 32'h66);
    check_val("orph_rdv", 64'(agt_rd_valid), 64'(0));
    cycle(0, 0, '0);
    check_val("orph_set", 64'(rd_orphan), 64'(1));
    for (int c = 0; c < 3; c++) cycle(0, 0, '0);
    check_val("orph_held", 64'(rd_orphan), 64'(1));

`ifdef SYS_MEM_ARB_PRIO_EN
    do_reset();
    refill = 1; new_req(0, 0); new_req(1, 0);
    for (int c = 0; c < 6; c++) cycle(0, 0, '0);
    for (int k = 0; k < 6; k++) check_val("prio_order", q_at(obs_acc, k), 64'(PRIO));
`endif

    // Randomized traffic with periodic resets.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < N; i++)
          if (!p_wr[i] && !p_rd[i] && ($urandom_range(0, 9) < 4))
            new_req(i, int'($urandom_range(0, 2)));
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
